// File: rtl/dti_apb_slave_regfile.sv
// APB4 completer register file: reg 0 = ID, reg 1 = status_i (read-only), regs 2.. = byte-strobed R/W.
// Optional wait states under `DTI_APB_SLV_WAIT_EN` (reg 3 [3:0] overrides WAIT_CYCLES when non-zero).
module dti_apb_slave_regfile #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          STRB_WIDTH  = DATA_WIDTH/8,
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] ID_VALUE    = 32'hD71A_0B01,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [STRB_WIDTH-1:0]          PSTRB,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  input  logic [DATA_WIDTH-1:0]          status_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic                           prot_err
);

  localparam int IW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state_q, state_d, phase;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
  logic [IW-1:0]           idx_q, idx_in, resp_idx;
  logic                    write_q, err_q, err_in, resp_write, resp_err;
  logic [DATA_WIDTH-1:0]   wdata_q, resp_data;
  logic [STRB_WIDTH-1:0]   strb_q;
  logic                    latch, set_ready, commit, viol, cnt_ready, setup_ready;

  assign idx_in = PADDR[IW+1:2];
  assign err_in = (PADDR >= ADDR_WIDTH'(NUM_REGS*4)) || (PADDR[1:0] != 2'b00) ||
                  (PWRITE && (idx_in < IW'(2)));

`ifdef DTI_APB_SLV_WAIT_EN
  logic [31:0] cnt_q, wait_sel;
  assign wait_sel    = (regs[3][3:0] != 4'd0) ? 32'(regs[3][3:0]) : 32'(WAIT_CYCLES);
  assign setup_ready = (wait_sel == 32'd0);
  // PREADY is registered, so it is raised on the edge where the counter expires
  assign cnt_ready   = (cnt_q <= 32'd1);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                                      cnt_q <= '0;
    else if (latch)                                    cnt_q <= wait_sel;
    else if (phase == ACCESS && !PREADY && cnt_q != 0) cnt_q <= cnt_q - 32'd1;
  end
`else
  assign setup_ready = 1'b1;
  assign cnt_ready   = 1'b1;
`endif

  // The registered state never holds SETUP: a setup cycle is recognised from IDLE plus the bus
  // pins, so back-to-back transfers pass ACCESS -> IDLE(reg) while decoding SETUP that cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    phase      = state_q;
    state_d    = state_q;
    latch      = 1'b0;
    set_ready  = 1'b0;
    commit     = 1'b0;
    viol       = 1'b0;
    resp_idx   = idx_q;
    resp_write = write_q;
    resp_err   = err_q;
    if (state_q == IDLE && PSEL && !PENABLE) phase = SETUP;
    case (phase)
      IDLE: viol = PSEL && PENABLE;
      SETUP: begin
        state_d    = ACCESS;
        latch      = 1'b1;
        resp_idx   = idx_in;
        resp_write = PWRITE;
        resp_err   = err_in;
        set_ready  = setup_ready;
      end
      ACCESS: begin
        if (!PSEL) begin
          viol    = 1'b1;
          state_d = IDLE;
        end else if (PREADY) begin
          state_d = IDLE;
          commit  = PENABLE && write_q && !err_q;
        end else begin
          set_ready = cnt_ready;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp_data = '0;
    if (!resp_write && !resp_err) begin
      if (resp_idx == IW'(0))      resp_data = ID_VALUE;
      else if (resp_idx == IW'(1)) resp_data = status_i;
      else                         resp_data = regs[resp_idx];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PRDATA   <= '0;
      PREADY   <= 1'b0;
      PSLVERR  <= 1'b0;
      prot_err <= 1'b0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      for (int unsigned n = 0; n < NUM_REGS; n++) regs[n] <= '0;
    end else begin
      prot_err <= viol;
      if (latch) begin
        idx_q   <= idx_in;
        write_q <= PWRITE;
        err_q   <= err_in;
        wdata_q <= PWDATA;
        strb_q  <= PSTRB;
      end
      if (set_ready) begin
        PREADY  <= 1'b1;
        PRDATA  <= resp_data;
        PSLVERR <= resp_err;
      end else begin
        PREADY  <= 1'b0;
        PRDATA  <= '0;
        PSLVERR <= 1'b0;
      end
      if (commit) begin
        for (int unsigned b = 0; b < STRB_WIDTH; b++)
          if (strb_q[b]) regs[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned n = 0; n < NUM_REGS; n++) reg_q[n*DATA_WIDTH +: DATA_WIDTH] = regs[n];
    reg_q[0 +: DATA_WIDTH]          = ID_VALUE;
    reg_q[DATA_WIDTH +: DATA_WIDTH] = status_i;
  end

endmodule
